// File: rtl/radio_btn_ctrl.sv
// radio_btn_ctrl
// Turns debounced front-panel button pulses into a live channel index and
// volume level, and hands coalesced snapshots of both to the I2C tuner
// register writer through a req/ready handshake followed by a done pulse.
// If no done pulse arrives within DONE_TIMEOUT cycles, the transfer is
// abandoned, o_err pulses for one cycle and the write is retried.
// Optional feature: define CHAN_WRAP_EN to make the channel wrap around at
// the band edges. By default the channel saturates at both edges.
module radio_btn_ctrl #(
  parameter int CHAN_MAX     = 205,
  parameter int CHAN_RESET   = 0,
  parameter int VOL_MAX      = 15,
  parameter int VOL_RESET    = 8,
  parameter int DONE_TIMEOUT = 4000000,
  parameter int CW           = $clog2(CHAN_MAX + 1),
  parameter int VW           = $clog2(VOL_MAX + 1)
) (
  input  logic          i_sysclk_40,
  input  logic          i_rst,
  input  logic          i_chan_up,
  input  logic          i_chan_dn,
  input  logic          i_vol_up,
  input  logic          i_vol_dn,
  output logic [CW-1:0] o_chan,
  output logic [VW-1:0] o_vol,
  output logic          o_req,
  input  logic          i_ready,
  output logic [CW-1:0] o_wr_chan,
  output logic [VW-1:0] o_wr_vol,
  input  logic          i_done,
  output logic          o_err
);

  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  localparam logic [CW-1:0] CHAN_MAX_C   = CW'(CHAN_MAX);
  localparam logic [CW-1:0] CHAN_RESET_C = CW'(CHAN_RESET);
  localparam logic [VW-1:0] VOL_MAX_C    = VW'(VOL_MAX);
  localparam logic [VW-1:0] VOL_RESET_C  = VW'(VOL_RESET);
  localparam logic [TW-1:0] TO_LAST_C    = TW'(DONE_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]    state_r;
  logic [TW-1:0] cnt_r;
  logic          dirty_r;
  logic [CW-1:0] chan_nxt_s;
  logic [VW-1:0] vol_nxt_s;
  logic          chan_chg_s;
  logic          vol_chg_s;
  logic          timeout_s;

  // Next channel value. Opposing pulses in the same cycle cancel out.
  always_comb begin
    chan_nxt_s = o_chan;
    chan_chg_s = 1'b0;
    if (i_chan_up && !i_chan_dn) begin
      if (o_chan == CHAN_MAX_C) begin
`ifdef CHAN_WRAP_EN
        chan_nxt_s = {CW{1'b0}};
        chan_chg_s = 1'b1;
`else
        chan_nxt_s = o_chan;
        chan_chg_s = 1'b0;
`endif
      end else begin
        chan_nxt_s = o_chan + CW'(1);
        chan_chg_s = 1'b1;
      end
    end else if (i_chan_dn && !i_chan_up) begin
      if (o_chan == {CW{1'b0}}) begin
`ifdef CHAN_WRAP_EN
        chan_nxt_s = CHAN_MAX_C;
        chan_chg_s = 1'b1;
`else
        chan_nxt_s = o_chan;
        chan_chg_s = 1'b0;
`endif
      end else begin
        chan_nxt_s = o_chan - CW'(1);
        chan_chg_s = 1'b1;
      end
    end else begin
      chan_nxt_s = o_chan;
      chan_chg_s = 1'b0;
    end
  end

  // Next volume value. Volume always saturates at both ends.
  always_comb begin
    vol_nxt_s = o_vol;
    vol_chg_s = 1'b0;
    if (i_vol_up && !i_vol_dn && (o_vol != VOL_MAX_C)) begin
      vol_nxt_s = o_vol + VW'(1);
      vol_chg_s = 1'b1;
    end else if (i_vol_dn && !i_vol_up && (o_vol != {VW{1'b0}})) begin
      vol_nxt_s = o_vol - VW'(1);
      vol_chg_s = 1'b1;
    end else begin
      vol_nxt_s = o_vol;
      vol_chg_s = 1'b0;
    end
  end

  // The writer never answered: an i_done in the last waiting cycle still counts.
  always_comb begin
    timeout_s = 1'b0;
    if ((state_r == ST_WAIT) && !i_done && (cnt_r == TO_LAST_C)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Live channel and volume registers, updated in every FSM state.
  always_ff @(posedge i_sysclk_40) begin
    if (i_rst) begin
      o_chan <= CHAN_RESET_C;
      o_vol  <= VOL_RESET_C;
    end else begin
      o_chan <= chan_nxt_s;
      o_vol  <= vol_nxt_s;
    end
  end

  // Dirty flag: a new value or a retry sets it, which wins over the clear taken in IDLE.
  always_ff @(posedge i_sysclk_40) begin
    if (i_rst) begin
      dirty_r <= 1'b1;
    end else if (chan_chg_s || vol_chg_s || timeout_s) begin
      dirty_r <= 1'b1;
    end else if ((state_r == ST_IDLE) && dirty_r) begin
      dirty_r <= 1'b0;
    end else begin
      dirty_r <= dirty_r;
    end
  end

  // Request handshake FSM with snapshot registers and the done-timeout counter.
  always_ff @(posedge i_sysclk_40) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {TW{1'b0}};
      o_req     <= 1'b0;
      o_err     <= 1'b0;
      o_wr_chan <= {CW{1'b0}};
      o_wr_vol  <= {VW{1'b0}};
    end else begin
      o_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (dirty_r) begin
            o_wr_chan <= o_chan;
            o_wr_vol  <= o_vol;
            o_req     <= 1'b1;
            state_r   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_ready) begin
            o_req   <= 1'b0;
            cnt_r   <= {TW{1'b0}};
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_done) begin
            state_r <= ST_IDLE;
          end else if (cnt_r == TO_LAST_C) begin
            o_err   <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + TW'(1);
          end
        end
        default: begin
          o_req   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
